// File: rtl/cnn_pkg.sv
// Shared types and elaboration-time helpers for the convolution address path.
package cnn_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of window positions along one dimension.
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // Bits needed to hold a counter value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_window_addr_gen_wrap_counter.sv
// Modulo-(MAX+1) counter; wrap flags the increment that rolls it back to zero
// so counters can be chained into a loop nest.
module wrap_counter
  import cnn_pkg::*;
#(
  parameter int MAX = 1,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_reg;

  assign cnt  = cnt_reg;
  assign wrap = inc && (cnt_reg == W'(MAX));

  // Count up on inc, roll over at MAX, clear on reset or sweep start.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (wrap) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Read-address generator for one KxK convolution sweep over an IMG_H x IMG_W
// tile. Four chained counters (kc, kr, ox, oy) track the tap currently on the
// output; the registered outputs are loaded from the counters' next values so
// addr and flags come straight from flops.
module conv_window_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int STRIDE     = 1,
  parameter int ADDR_WIDTH = $clog2(IMG_W * IMG_H)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_vld,
  input  logic                  addr_rdy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  win_first,
  output logic                  win_last,
  output logic                  frame_last
);

  localparam int OUT_W   = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H   = out_dim(IMG_H, K, STRIDE);
  localparam int MAX_A   = (K - 1 > OUT_W - 1) ? K - 1 : OUT_W - 1;
  localparam int MAX_CNT = (MAX_A > OUT_H - 1) ? MAX_A : OUT_H - 1;
  localparam int CNT_W   = cnt_width(MAX_CNT);
  localparam int IW      = ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  // Level 0 = kc (innermost), 1 = kr, 2 = ox, 3 = oy (outermost).
  function automatic int level_max(input int lvl);
    case (lvl)
      0:       return K - 1;
      1:       return K - 1;
      2:       return OUT_W - 1;
      default: return OUT_H - 1;
    endcase
  endfunction

  logic [1:0]            state_reg;
  logic                  busy_reg, done_reg, vld_reg;
  logic                  wf_reg, wl_reg, fl_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;

  logic                  start_acc, hs;
  logic [3:0]            inc_vec, wrap_vec;
  logic [CNT_W-1:0]      cnt_arr [4];
  logic [CNT_W-1:0]      nxt_arr [4];

  logic [IW-1:0]         row_next, addr_full_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  wf_next, wl_next, fl_next;
  logic                  unused_addr_msb;

  assign start_acc = (state_reg == S_IDLE) && start;
  assign hs        = (state_reg == S_RUN) && vld_reg && addr_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lvl
      if (gi == 0) begin : g_head
        assign inc_vec[gi] = hs;
      end else begin : g_tail
        assign inc_vec[gi] = wrap_vec[gi-1];
      end

      wrap_counter #(
        .MAX (level_max(gi)),
        .W   (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_vec[gi]),
        .clr   (start_acc),
        .cnt   (cnt_arr[gi]),
        .wrap  (wrap_vec[gi])
      );

      // Value this counter will hold after the current clock edge.
      assign nxt_arr[gi] = start_acc     ? '0 :
                           !inc_vec[gi]  ? cnt_arr[gi] :
                           wrap_vec[gi]  ? '0 :
                                           cnt_arr[gi] + 1'b1;
    end
  endgenerate

  // Address and flag decode of the tap that will be presented next.
  always_comb begin
    row_next       = IW'(nxt_arr[3]) * IW'(STRIDE) + IW'(nxt_arr[1]);
    addr_full_next = row_next * IW'(IMG_W) + IW'(nxt_arr[2]) * IW'(STRIDE) + IW'(nxt_arr[0]);
    wf_next        = (nxt_arr[1] == '0) && (nxt_arr[0] == '0);
    wl_next        = (nxt_arr[1] == CNT_W'(K - 1)) && (nxt_arr[0] == CNT_W'(K - 1));
    fl_next        = wl_next && (nxt_arr[2] == CNT_W'(OUT_W - 1)) && (nxt_arr[3] == CNT_W'(OUT_H - 1));
  end

  assign addr_next       = addr_full_next[ADDR_WIDTH-1:0];
  assign unused_addr_msb = addr_full_next[IW-1];

  // Sweep FSM and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      vld_reg   <= 1'b0;
      addr_reg  <= '0;
      wf_reg    <= 1'b0;
      wl_reg    <= 1'b0;
      fl_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_RUN;
            busy_reg  <= 1'b1;
            vld_reg   <= 1'b1;
            addr_reg  <= addr_next;
            wf_reg    <= wf_next;
            wl_reg    <= wl_next;
            fl_reg    <= fl_next;
          end
        end
        S_RUN: begin
          if (hs) begin
            if (fl_reg) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
              vld_reg   <= 1'b0;
              addr_reg  <= '0;
              wf_reg    <= 1'b0;
              wl_reg    <= 1'b0;
              fl_reg    <= 1'b0;
            end else begin
              addr_reg <= addr_next;
              wf_reg   <= wf_next;
              wl_reg   <= wl_next;
              fl_reg   <= fl_next;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          vld_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign addr_vld   = vld_reg;
  assign addr       = addr_reg;
  assign win_first  = wf_reg;
  assign win_last   = wl_reg;
  assign frame_last = fl_reg;

endmodule
